// File: rtl/dp_ram_mailbox_pkg.sv
// Shared types and constants for the dual-port RAM mailbox sequencer.
package dp_ram_mailbox_pkg;

  typedef enum logic [3:0] {
    IDLE,
    POLL,
    READ_IN,
    DRAIN,
    START,
    WAIT_OP,
    WRITE_OUT,
    SET_FINISH,
    ACK_RD,
    ACK_CHK,
    CLEAR
  } mbox_state_t;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dp_ram_mailbox_timeout.sv
// WAIT_OP cycle counter; o_hit flags the final permitted cycle. TIMEOUT=0 ties it off.
module dp_ram_mailbox_timeout #(
  parameter int TIMEOUT = 0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_hit
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{CLK, RESET, i_clear, i_enable};
      assign o_hit    = 1'b0;
    end else begin : g_on
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [TW-1:0] r_count;

      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          r_count <= '0;
        end else if (i_clear) begin
          r_count <= '0;
        end else if (i_enable && !o_hit) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign o_hit = (r_count == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/dp_ram_mailbox_ctrl.sv
// Mailbox sequencer: polls the control word, fetches operands, runs the engine,
// writes results and status back, then waits for the host ack and clears control.
module dp_ram_mailbox_ctrl
  import dp_ram_mailbox_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 4,
  parameter int N_IN        = 2,
  parameter int N_OUT       = 2,
  parameter int CTRL_ADDR   = 0,
  parameter int STATUS_ADDR = 1,
  parameter int IN_BASE     = 2,
  parameter int OUT_BASE    = IN_BASE + N_IN,
  parameter int START_BIT   = 0,
  parameter int ACK_BIT     = 9,
  parameter int TIMEOUT     = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_rd_en,
  output logic                ram_wr_en,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata,
  output logic                op_start,
  output logic [N_IN*DW-1:0]  op_operands,
  input  logic                op_done,
  input  logic [N_OUT*DW-1:0] op_result,
  output logic                busy,
  output logic                timeout_err
);

  localparam int NMAX = max2(N_IN, N_OUT);
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  mbox_state_t        r_state;
  mbox_state_t        w_next;
  logic               r_run;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_rdIdx;
  logic               r_rdValid;
  logic [N_IN*DW-1:0] r_operands;
  logic [N_OUT*DW-1:0] r_result;
  logic               r_timeoutErr;
  logic               w_hit;
  logic               w_toClear;
  logic               w_toEnable;
  logic [AW-1:0]      w_addr;
  logic               w_rdEn;
  logic               w_wrEn;
  logic [DW-1:0]      w_wdata;
  logic               w_opStart;
  logic               w_busy;

  // r_run holds every strobe low until the first edge after reset releases.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_addr    = '0;
    w_rdEn    = 1'b0;
    w_wrEn    = 1'b0;
    w_wdata   = '0;
    w_opStart = 1'b0;
    w_busy    = 1'b0;
    if (!r_run) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_rdEn = 1'b1;
          w_addr = AW'(CTRL_ADDR);
          w_next = POLL;
        end
        POLL: begin
          w_next = ram_rdata[START_BIT] ? READ_IN : IDLE;
        end
        READ_IN: begin
          w_busy = 1'b1;
          w_rdEn = 1'b1;
          w_addr = AW'(IN_BASE) + AW'(r_idx);
          if (r_idx == IW'(N_IN - 1)) w_next = DRAIN;
        end
        DRAIN: begin
          w_busy = 1'b1;
          w_next = START;
        end
        START: begin
          w_busy             = 1'b1;
          w_opStart          = 1'b1;
          w_wrEn             = 1'b1;
          w_addr             = AW'(STATUS_ADDR);
          w_wdata[STAT_BUSY] = 1'b1;
          w_next             = WAIT_OP;
        end
        WAIT_OP: begin
          w_busy = 1'b1;
          if (op_done)    w_next = WRITE_OUT;
          else if (w_hit) w_next = SET_FINISH;
        end
        WRITE_OUT: begin
          w_busy  = 1'b1;
          w_wrEn  = 1'b1;
          w_addr  = AW'(OUT_BASE) + AW'(r_idx);
          w_wdata = r_result[int'(r_idx)*DW +: DW];
          if (r_idx == IW'(N_OUT - 1)) w_next = SET_FINISH;
        end
        SET_FINISH: begin
          w_busy             = 1'b1;
          w_wrEn             = 1'b1;
          w_addr             = AW'(STATUS_ADDR);
          w_wdata[STAT_DONE] = 1'b1;
          w_wdata[STAT_ERR]  = r_timeoutErr;
          w_next             = ACK_RD;
        end
        ACK_RD: begin
          w_busy = 1'b1;
          w_rdEn = 1'b1;
          w_addr = AW'(CTRL_ADDR);
          w_next = ACK_CHK;
        end
        ACK_CHK: begin
          w_busy = 1'b1;
          w_next = ram_rdata[ACK_BIT] ? CLEAR : ACK_RD;
        end
        CLEAR: begin
          w_busy = 1'b1;
          w_wrEn = 1'b1;
          w_addr = AW'(CTRL_ADDR);
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Read data trails the address by one cycle, so the slot index is delayed with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_idx        <= '0;
      r_rdIdx      <= '0;
      r_rdValid    <= 1'b0;
      r_operands   <= '0;
      r_result     <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_rdValid <= (r_state == READ_IN);
      r_rdIdx   <= r_idx;
      if (r_rdValid) r_operands[int'(r_rdIdx)*DW +: DW] <= ram_rdata;
      case (r_state)
        POLL:               r_idx <= '0;
        READ_IN, WRITE_OUT: r_idx <= r_idx + 1'b1;
        START:              r_timeoutErr <= 1'b0;
        WAIT_OP: begin
          if (op_done) begin
            r_result <= op_result;
            r_idx    <= '0;
          end else if (w_hit) begin
            r_timeoutErr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_toClear  = (r_state == START);
  assign w_toEnable = (r_state == WAIT_OP) && !op_done;

  dp_ram_mailbox_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_clear (w_toClear),
    .i_enable(w_toEnable),
    .o_hit   (w_hit)
  );

  assign ram_addr    = w_addr;
  assign ram_rd_en   = w_rdEn;
  assign ram_wr_en   = w_wrEn;
  assign ram_wdata   = w_wdata;
  assign op_start    = w_opStart;
  assign busy        = w_busy;
  assign op_operands = r_operands;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_dp_ram_mailbox_ctrl.sv
// Scoreboard bench: dutA (defaults, TIMEOUT=8) and dutB (AW=5, N_IN=4, N_OUT=1)
// each sit on a RAM model with a host port and a behavioural engine.
module tb_dp_ram_mailbox_ctrl;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk  = 1'b0;
  logic rstN = 1'b1;

  int nCompared   = 0;
  int nMismatched = 0;

  wr_t          expWrA[$];
  wr_t          expWrB[$];
  logic [63:0]  expOpA[$];
  logic [127:0] expOpB[$];

  int wrCntA = 0, rdCntA = 0, pollCntA = 0, startCntA = 0;
  int wrCntB = 0, rdCntB = 0, pollCntB = 0, startCntB = 0, wr6CntB = 0;

  // dutA signals
  logic [3:0]  ramAddrA;
  logic        rdEnA, wrEnA, opStartA, busyA, errA;
  logic [31:0] wdataA;
  logic [31:0] rdataA = '0;
  logic [63:0] operandsA;
  logic        opDoneA = 1'b0;
  logic [63:0] opResultA = '0;
  logic [31:0] ramA [16] = '{default: 32'd0};
  logic        hostWeA = 1'b0;
  logic [3:0]  hostAddrA = '0;
  logic [31:0] hostDataA = '0;
  int          engDelayA = 0;
  bit          engNeverA = 1'b0;
  bit          engArmedA = 1'b0;
  int          engCntA = 0;

  // dutB signals
  logic [4:0]   ramAddrB;
  logic         rdEnB, wrEnB, opStartB, busyB, errB;
  logic [31:0]  wdataB;
  logic [31:0]  rdataB = '0;
  logic [127:0] operandsB;
  logic         opDoneB = 1'b0;
  logic [31:0]  opResultB = '0;
  logic [31:0]  ramB [32] = '{default: 32'd0};
  logic         hostWeB = 1'b0;
  logic [4:0]   hostAddrB = '0;
  logic [31:0]  hostDataB = '0;
  bit           engArmedB = 1'b0;
  int           engCntB = 0;

  always #5 clk = ~clk;

  dp_ram_mailbox_ctrl #(.TIMEOUT(8)) dutA (
    .CLK(clk), .RESET(rstN),
    .ram_addr(ramAddrA), .ram_rd_en(rdEnA), .ram_wr_en(wrEnA),
    .ram_wdata(wdataA), .ram_rdata(rdataA),
    .op_start(opStartA), .op_operands(operandsA),
    .op_done(opDoneA), .op_result(opResultA),
    .busy(busyA), .timeout_err(errA)
  );

  dp_ram_mailbox_ctrl #(.AW(5), .N_IN(4), .N_OUT(1)) dutB (
    .CLK(clk), .RESET(rstN),
    .ram_addr(ramAddrB), .ram_rd_en(rdEnB), .ram_wr_en(wrEnB),
    .ram_wdata(wdataB), .ram_rdata(rdataB),
    .op_start(opStartB), .op_operands(operandsB),
    .op_done(opDoneB), .op_result(opResultB),
    .busy(busyB), .timeout_err(errB)
  );

  // Dual-port RAM models: host port plus the FPGA port driven by each DUT.
  always @(posedge clk) begin
    if (hostWeA) ramA[hostAddrA] <= hostDataA;
    if (wrEnA)   ramA[ramAddrA]  <= wdataA;
    if (rdEnA)   rdataA          <= ramA[ramAddrA];
    if (hostWeB) ramB[hostAddrB] <= hostDataB;
    if (wrEnB)   ramB[ramAddrB]  <= wdataB;
    if (rdEnB)   rdataB          <= ramB[ramAddrB];
  end

  // Engine A multiplies operand 0 by operand 1; engine B sums its four operands.
  always @(posedge clk) begin
    opDoneA <= 1'b0;
    if (opStartA) begin
      engArmedA <= !engNeverA;
      engCntA   <= engDelayA;
    end else if (engArmedA) begin
      if (engCntA == 0) begin
        opDoneA   <= 1'b1;
        opResultA <= 64'(operandsA[31:0]) * 64'(operandsA[63:32]);
        engArmedA <= 1'b0;
      end else begin
        engCntA <= engCntA - 1;
      end
    end
    opDoneB <= 1'b0;
    if (opStartB) begin
      engArmedB <= 1'b1;
      engCntB   <= 2;
    end else if (engArmedB) begin
      if (engCntB == 0) begin
        opDoneB   <= 1'b1;
        opResultB <= operandsB[31:0] + operandsB[63:32] + operandsB[95:64] + operandsB[127:96];
        engArmedB <= 1'b0;
      end else begin
        engCntB <= engCntB - 1;
      end
    end
  end

  // Scoreboard monitors: every write and every op_start is checked against the queues.
  always @(negedge clk) begin : monA
    wr_t         e;
    logic [63:0] eo;
    if (rstN) begin
      if (wrEnA) begin
        wrCntA++;
        nCompared++;
        if (expWrA.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL wrA_unexpected: got addr=%0d data=%h, want no write", ramAddrA, wdataA);
        end else begin
          e = expWrA.pop_front();
          if (ramAddrA !== e.addr[3:0] || wdataA !== e.data) begin
            nMismatched++;
            $display("[TB] FAIL wrA: got addr=%0d data=%h, want addr=%0d data=%h",
                     ramAddrA, wdataA, e.addr, e.data);
          end
        end
        if (rdEnA) begin
          nMismatched++;
          $display("[TB] FAIL strobeA: got rd_en=1 with wr_en=1, want exclusive");
        end
      end
      if (rdEnA) begin
        rdCntA++;
        if (ramAddrA == 4'd0) pollCntA++;
      end
      if (opStartA) begin
        startCntA++;
        nCompared++;
        if (expOpA.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL opStartA_unexpected: got op_start, want none");
        end else begin
          eo = expOpA.pop_front();
          if (operandsA !== eo) begin
            nMismatched++;
            $display("[TB] FAIL operandsA: got %h, want %h", operandsA, eo);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monB
    wr_t          e;
    logic [127:0] eo;
    if (rstN) begin
      if (wrEnB) begin
        wrCntB++;
        if (ramAddrB == 5'd6) wr6CntB++;
        nCompared++;
        if (expWrB.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL wrB_unexpected: got addr=%0d data=%h, want no write", ramAddrB, wdataB);
        end else begin
          e = expWrB.pop_front();
          if (ramAddrB !== e.addr || wdataB !== e.data) begin
            nMismatched++;
            $display("[TB] FAIL wrB: got addr=%0d data=%h, want addr=%0d data=%h",
                     ramAddrB, wdataB, e.addr, e.data);
          end
        end
        if (rdEnB) begin
          nMismatched++;
          $display("[TB] FAIL strobeB: got rd_en=1 with wr_en=1, want exclusive");
        end
      end
      if (rdEnB) begin
        rdCntB++;
        if (ramAddrB == 5'd0) pollCntB++;
      end
      if (opStartB) begin
        startCntB++;
        nCompared++;
        if (expOpB.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL opStartB_unexpected: got op_start, want none");
        end else begin
          eo = expOpB.pop_front();
          if (operandsB !== eo) begin
            nMismatched++;
            $display("[TB] FAIL operandsB: got %h, want %h", operandsB, eo);
          end
        end
      end
    end
  end

  task automatic hostWriteA(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    hostWeA = 1'b1; hostAddrA = a; hostDataA = d;
    @(negedge clk);
    hostWeA = 1'b0;
  endtask

  task automatic hostWriteB(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    hostWeB = 1'b1; hostAddrB = a; hostDataB = d;
    @(negedge clk);
    hostWeB = 1'b0;
  endtask

  task automatic pushWrA(input logic [4:0] a, input logic [31:0] d);
    expWrA.push_back('{addr: a, data: d});
  endtask

  task automatic pushWrB(input logic [4:0] a, input logic [31:0] d);
    expWrB.push_back('{addr: a, data: d});
  endtask

  task automatic waitRamA(input logic [3:0] a, input logic [31:0] v, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ramA[a] === v) begin hit = 1'b1; break; end
    end
  endtask

  task automatic waitRamB(input logic [4:0] a, input logic [31:0] v, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ramB[a] === v) begin hit = 1'b1; break; end
    end
  endtask

  task automatic waitOpStartA(output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (opStartA) begin hit = 1'b1; break; end
    end
  endtask

  task automatic ackAndClearA(input string name);
    bit hit;
    hostWriteA(4'd0, 32'h0000_0201);
    waitRamA(4'd0, 32'd0, hit);
    nCompared++;
    if (!hit) begin
      nMismatched++;
      $display("[TB] FAIL %s_clear: got ctrl=%h, want 0", name, ramA[0]);
    end
    repeat (3) @(negedge clk);
    nCompared++;
    if (expWrA.size() != 0 || busyA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_end: got pending=%0d busy=%b, want 0 and 0", name, expWrA.size(), busyA);
    end
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    #1;
    nCompared++;
    if ({rdEnA, wrEnA, opStartA, busyA, errA, ramAddrA, wdataA, operandsA} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL resetA: got rd=%b wr=%b st=%b busy=%b err=%b addr=%h wd=%h ops=%h, want all 0",
               rdEnA, wrEnA, opStartA, busyA, errA, ramAddrA, wdataA, operandsA);
    end
    nCompared++;
    if ({rdEnB, wrEnB, opStartB, busyB, errB, ramAddrB, wdataB, operandsB} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL resetB: got rd=%b wr=%b st=%b busy=%b err=%b addr=%h wd=%h ops=%h, want all 0",
               rdEnB, wrEnB, opStartB, busyB, errB, ramAddrB, wdataB, operandsB);
    end
    repeat (3) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_idle();
    int w0, r0, p0, s0, wb0, rb0, pb0, sb0;
    @(negedge clk); #1;
    w0 = wrCntA; r0 = rdCntA; p0 = pollCntA; s0 = startCntA;
    wb0 = wrCntB; rb0 = rdCntB; pb0 = pollCntB; sb0 = startCntB;
    repeat (100) @(negedge clk);
    #1;
    nCompared++;
    if (wrCntA - w0 != 0 || startCntA - s0 != 0 || pollCntA - p0 != 50 || rdCntA - r0 != 50) begin
      nMismatched++;
      $display("[TB] FAIL idleA: got wr=%0d start=%0d polls=%0d reads=%0d, want 0 0 50 50",
               wrCntA - w0, startCntA - s0, pollCntA - p0, rdCntA - r0);
    end
    nCompared++;
    if (wrCntB - wb0 != 0 || startCntB - sb0 != 0 || pollCntB - pb0 != 50 || rdCntB - rb0 != 50) begin
      nMismatched++;
      $display("[TB] FAIL idleB: got wr=%0d start=%0d polls=%0d reads=%0d, want 0 0 50 50",
               wrCntB - wb0, startCntB - sb0, pollCntB - pb0, rdCntB - rb0);
    end
  endtask

  task automatic test_basic_multiply();
    bit hit;
    int s0;
    engNeverA = 1'b0; engDelayA = 0;
    hostWriteA(4'd2, 32'd3);
    hostWriteA(4'd3, 32'd5);
    hostWriteA(4'd4, 32'hDEAD_0004);
    hostWriteA(4'd5, 32'hDEAD_0005);
    expOpA.push_back({32'd5, 32'd3});
    pushWrA(5'd1, 32'd1); pushWrA(5'd4, 32'd15); pushWrA(5'd5, 32'd0);
    pushWrA(5'd1, 32'd2); pushWrA(5'd0, 32'd0);
    s0 = startCntA;
    hostWriteA(4'd0, 32'd1);
    waitRamA(4'd1, 32'd2, hit);
    nCompared++;
    if (!hit) begin
      nMismatched++;
      $display("[TB] FAIL basic_status: got %h, want 00000002", ramA[1]);
    end
    nCompared++;
    if (ramA[4] !== 32'd15 || ramA[5] !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL basic_result: got %h %h, want 0000000f 00000000", ramA[4], ramA[5]);
    end
    nCompared++;
    if (startCntA - s0 != 1) begin
      nMismatched++;
      $display("[TB] FAIL basic_startcount: got %0d, want 1", startCntA - s0);
    end
    ackAndClearA("basic");
  endtask

  task automatic test_timeout();
    bit hit;
    int cyc;
    engNeverA = 1'b1;
    hostWriteA(4'd2, 32'd6);
    hostWriteA(4'd3, 32'd7);
    hostWriteA(4'd4, 32'h1111_AAAA);
    hostWriteA(4'd5, 32'h2222_BBBB);
    expOpA.push_back({32'd7, 32'd6});
    pushWrA(5'd1, 32'd1); pushWrA(5'd1, 32'd6); pushWrA(5'd0, 32'd0);
    hostWriteA(4'd0, 32'd1);
    waitOpStartA(hit);
    cyc = -1;
    if (hit) begin
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (errA) begin cyc = k; break; end
      end
    end
    // START cycle, then TIMEOUT WAIT_OP cycles, then the flag is visible.
    nCompared++;
    if (cyc != 9) begin
      nMismatched++;
      $display("[TB] FAIL timeout_latency: got %0d cycles, want 9", cyc);
    end
    waitRamA(4'd1, 32'd6, hit);
    nCompared++;
    if (!hit) begin
      nMismatched++;
      $display("[TB] FAIL timeout_status: got %h, want 00000006", ramA[1]);
    end
    nCompared++;
    if (ramA[4] !== 32'h1111_AAAA || ramA[5] !== 32'h2222_BBBB || errA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_keep: got %h %h err=%b, want 1111aaaa 2222bbbb err=1", ramA[4], ramA[5], errA);
    end
    ackAndClearA("timeout");
  endtask

  task automatic test_coincide();
    bit hit;
    engNeverA = 1'b0; engDelayA = 6;
    hostWriteA(4'd2, 32'd7);
    hostWriteA(4'd3, 32'd9);
    expOpA.push_back({32'd9, 32'd7});
    pushWrA(5'd1, 32'd1); pushWrA(5'd4, 32'd63); pushWrA(5'd5, 32'd0);
    pushWrA(5'd1, 32'd2); pushWrA(5'd0, 32'd0);
    hostWriteA(4'd0, 32'd1);
    waitOpStartA(hit);
    nCompared++;
    if (!hit || errA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL coincide_errheld: got start=%b err=%b, want start=1 err=1", hit, errA);
    end
    @(negedge clk);
    nCompared++;
    if (errA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL coincide_errclear: got %b, want 0", errA);
    end
    waitRamA(4'd1, 32'd2, hit);
    nCompared++;
    if (!hit || ramA[4] !== 32'd63 || ramA[5] !== 32'd0 || errA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL coincide_result: got status=%h %h %h err=%b, want 2 3f 0 err=0",
               ramA[1], ramA[4], ramA[5], errA);
    end
    ackAndClearA("coincide");
  endtask

  task automatic test_reset_midop();
    bit hit;
    int wrDuring;
    engNeverA = 1'b1;
    hostWriteA(4'd2, 32'd2);
    hostWriteA(4'd3, 32'd4);
    expOpA.push_back({32'd4, 32'd2});
    pushWrA(5'd1, 32'd1);
    hostWriteA(4'd0, 32'd1);
    waitOpStartA(hit);
    repeat (3) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    nCompared++;
    if (!hit || {rdEnA, wrEnA, opStartA, busyA, errA, ramAddrA, wdataA, operandsA} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got rd=%b wr=%b st=%b busy=%b addr=%h wd=%h ops=%h, want all 0",
               rdEnA, wrEnA, opStartA, busyA, ramAddrA, wdataA, operandsA);
    end
    wrDuring = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wrEnA) wrDuring++;
    end
    nCompared++;
    if (wrDuring != 0 || ramA[1] !== 32'd1 || expWrA.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_hold: got writes=%0d status=%h pending=%0d, want 0 1 0",
               wrDuring, ramA[1], expWrA.size());
    end
    engNeverA = 1'b0; engDelayA = 1;
    expOpA.push_back({32'd4, 32'd2});
    pushWrA(5'd1, 32'd1); pushWrA(5'd4, 32'd8); pushWrA(5'd5, 32'd0);
    pushWrA(5'd1, 32'd2); pushWrA(5'd0, 32'd0);
    rstN = 1'b1;
    waitRamA(4'd1, 32'd2, hit);
    nCompared++;
    if (!hit || ramA[4] !== 32'd8 || ramA[5] !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_rerun: got status=%h %h %h, want 2 8 0", ramA[1], ramA[4], ramA[5]);
    end
    ackAndClearA("midreset");
  endtask

  task automatic test_param();
    bit hit;
    int w6;
    hostWriteB(5'd2, 32'h11);
    hostWriteB(5'd3, 32'h22);
    hostWriteB(5'd4, 32'h33);
    hostWriteB(5'd5, 32'h44);
    hostWriteB(5'd6, 32'hCAFE_0006);
    hostWriteB(5'd7, 32'hCAFE_0007);
    expOpB.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    pushWrB(5'd1, 32'd1); pushWrB(5'd6, 32'hAA); pushWrB(5'd1, 32'd2); pushWrB(5'd0, 32'd0);
    w6 = wr6CntB;
    hostWriteB(5'd0, 32'd1);
    waitRamB(5'd1, 32'd2, hit);
    nCompared++;
    if (!hit || ramB[6] !== 32'hAA || ramB[7] !== 32'hCAFE_0007) begin
      nMismatched++;
      $display("[TB] FAIL param_result: got status=%h r6=%h r7=%h, want 2 aa cafe0007",
               ramB[1], ramB[6], ramB[7]);
    end
    nCompared++;
    if (wr6CntB - w6 != 1) begin
      nMismatched++;
      $display("[TB] FAIL param_outwrites: got %0d, want 1", wr6CntB - w6);
    end
    hostWriteB(5'd0, 32'h0000_0201);
    waitRamB(5'd0, 32'd0, hit);
    repeat (3) @(negedge clk);
    nCompared++;
    if (!hit || expWrB.size() != 0 || busyB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL param_end: got ctrl=%h pending=%0d busy=%b, want 0 0 0",
               ramB[0], expWrB.size(), busyB);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic_multiply();
    test_timeout();
    test_coincide();
    test_reset_midop();
    test_param();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
